load_sequencer: RTL
===================

# load_sequencer

Upstream feeder for the dataload stage. Accepts a valid/ready stream of 32-bit words from the host interface and converts it into the `data_i` / `load_en_i` / `load_type` pulse sequence dataload consumes: one weight word, then WORDS_PER_TILE input words, per tile. Throttles between tiles until the compute array acknowledges the loaded tile, so the shift buffers are never overwritten mid-use.

## Interface
- `WORDS_PER_TILE`, 8: input words per tile; 8 × 32 = 256 fills the first-level input buffer.
- `CNT_W`, 16: width of tile count and tile counter.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start_i`  in  1  start pulse; samples `tile_count_i` (and `weight_reuse_i`) in IDLE.
- `tile_count_i`  in  CNT_W  number of tiles to load.
- `weight_reuse_i`  in  1  load the weight only for tile 0 (honoured only with `LOAD_SEQ_WEIGHT_REUSE_EN`).
- `s_data_i`  in  32  host word.
- `s_valid_i`  in  1  host word valid.
- `s_ready_o`  out  1  sequencer accepts word.
- `tile_ack_i`  in  1  compute has consumed current tile.
- `data_o`  out  32  to dataload `data_i`.
- `load_en_o`  out  1  to dataload `load_en_i`.
- `load_type_o`  out  1  to dataload `load_type`; 0 = weight, 1 = input.
- `busy_o`  out  1  state ≠ IDLE.
- `done_o`  out  1  one-cycle pulse after final tile acknowledged.

## Operation
- States: IDLE, LOAD_W, LOAD_I, WAIT_ACK, DONE.
- IDLE: on `start_i`, latch `tile_count_i` and reuse flag, clear tile and word counters. If `tile_count_i == 0`, go to DONE; else go to LOAD_W.
- LOAD_W: `s_ready_o = 1`. On handshake, emit the word as a weight load and go to LOAD_I.
- LOAD_I: `s_ready_o = 1`. Each handshake emits an input load and increments `word_cnt`. On handshake with `word_cnt == WORDS_PER_TILE-1`, clear `word_cnt` and go to WAIT_ACK.
- WAIT_ACK: `s_ready_o = 0`. On `tile_ack_i`:
  - If `tile_cnt == count-1`, go to DONE.
  - Otherwise increment `tile_cnt` and go to LOAD_W, or to LOAD_I when reuse is active.
- DONE: `done_o = 1` for this single cycle, then IDLE.
- `s_ready_o` is decoded combinationally from state only and never depends on `s_valid_i`.
- Ignored inputs:
  - `start_i` outside IDLE.
  - `tile_ack_i` outside WAIT_ACK.
  - `s_valid_i` while `s_ready_o = 0`; the word stays pending at the host.
- `tile_cnt` compares against the latched count. Changes on `tile_count_i` during a run have no effect.
- A count of 2^CNT_W − 1 is legal and must not wrap early.

## Timing
- Reset values:
  - state = IDLE; `data_o` = 0; `load_en_o` = 0; `load_type_o` = 0.
  - `s_ready_o` = 0; `busy_o` = 0; `done_o` = 0; all counters 0.
- `data_o`, `load_en_o` and `load_type_o` are registered. A handshake in cycle N produces `load_en_o = 1` with that word in cycle N+1.
- In any cycle without a handshake, `load_en_o = 0` and `data_o` holds its last value.
- Full throughput: with `s_valid_i` held high, a tile occupies 1 + WORDS_PER_TILE consecutive accepting cycles.
- Last input handshake at cycle N moves the state to WAIT_ACK at N+1.
- A `tile_ack_i` already high in that first WAIT_ACK cycle is honoured, so the next tile can begin accepting at N+2.
- `done_o` asserts the cycle after the final `tile_ack_i`. `busy_o` drops the cycle after `done_o`.
- Asserting `rst_n` low mid-tile returns to IDLE asynchronously and clears every output. The partially loaded tile is discarded, and the host must restart.

## Configuration
- `LOAD_SEQ_WEIGHT_REUSE_EN` defined:
  - `weight_reuse_i` is latched at start.
  - When it was 1, tiles 1…count-1 skip LOAD_W and go WAIT_ACK → LOAD_I.
- Not defined: `weight_reuse_i` is ignored and every tile loads one weight word first.

## Test plan
- Reset, `start_i` with count 1, continuous valid words 0x100..0x108:
  - loads are (type 0, 0x100) followed by type 1, 0x101..0x108 on consecutive cycles;
  - WAIT_ACK holds until `tile_ack_i`;
  - `done_o` pulses once, then IDLE.
- Count 2 with `s_valid_i` toggling every other cycle: `load_en_o` pulses only on handshakes; 18 loads total in exact order; no `s_ready_o` during WAIT_ACK.
- Count 0: `done_o` pulses the cycle after DONE entry; zero loads; `s_ready_o` never high.
- `start_i` and spurious `tile_ack_i` during LOAD_I: both ignored; word order and `tile_cnt` unchanged.
- `rst_n` low after 4 input words: all outputs 0 immediately. A new start with count 1 then yields a clean 9-word sequence.
- `LOAD_SEQ_WEIGHT_REUSE_EN` defined, count 3, `weight_reuse_i = 1`: exactly one type-0 load followed by 24 type-1 loads. With the macro undefined, the same stimulus gives 3 type-0 loads.

Source files
------------

// File: rtl/load_sequencer.sv
// load_sequencer
//
// Upstream feeder for the dataload stage. Converts a valid/ready stream of
// 32-bit host words into the data/load_en/load_type pulse sequence that
// dataload consumes. Each tile is one weight word followed by WORDS_PER_TILE
// input words. After each tile the sequencer stops accepting words until
// compute acknowledges the tile, so the shift buffers are never overwritten
// while in use.
//
// Optional feature macro: LOAD_SEQ_WEIGHT_REUSE_EN
//   When defined, weight_reuse_i is latched at start. If it was 1, only
//   tile 0 loads a weight word. Later tiles go straight to input words.
//   When not defined, weight_reuse_i is ignored and every tile loads a
//   weight word first.
//
// Parameters:
//   WORDS_PER_TILE  input words per tile
//   CNT_W           width of the tile count and the tile counter
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   start_i         start pulse; tile_count_i/weight_reuse_i sampled in IDLE
//   tile_count_i    number of tiles to load
//   weight_reuse_i  load the weight only for tile 0 (feature macro only)
//   s_data_i        host word
//   s_valid_i       host word valid
//   s_ready_o       sequencer accepts word (decoded from state only)
//   tile_ack_i      compute has consumed the current tile
//   data_o          registered word to dataload
//   load_en_o       registered one-cycle load strobe
//   load_type_o     registered load type, 0 = weight, 1 = input
//   busy_o          sequencer not idle
//   done_o          one-cycle pulse after the final tile is acknowledged
module load_sequencer #(
    parameter int WORDS_PER_TILE = 8,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] tile_count_i,
    input  logic             weight_reuse_i,
    input  logic [31:0]      s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic             tile_ack_i,
    output logic [31:0]      data_o,
    output logic             load_en_o,
    output logic             load_type_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int WC_W = (WORDS_PER_TILE > 1) ? $clog2(WORDS_PER_TILE) : 1;
    localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(WORDS_PER_TILE - 1);
    localparam logic [WC_W-1:0]  WORD_ONE  = WC_W'(1);
    localparam logic [CNT_W-1:0] TILE_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_W   = 3'd1,
        LOAD_I   = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] tile_cnt_reg;
    logic [WC_W-1:0]  word_cnt_reg;
    logic             handshake;
    logic             last_word;
    logic             last_tile;
    logic             reuse_active;

    // Ready is a pure state decode so the host can never see it react to
    // its own valid.
    assign s_ready_o = (state_reg == LOAD_W) || (state_reg == LOAD_I);
    assign busy_o    = (state_reg != IDLE);
    assign done_o    = (state_reg == DONE);
    assign handshake = s_valid_i && s_ready_o;
    assign last_word = (word_cnt_reg == WORD_LAST);
    // A zero count never reaches WAIT_ACK, so count_reg - 1 cannot
    // underflow here. A count of all ones compares correctly at full width.
    assign last_tile = (tile_cnt_reg == (count_reg - TILE_ONE));

`ifdef LOAD_SEQ_WEIGHT_REUSE_EN
    logic reuse_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reuse_reg <= 1'b0;
        end else if (state_reg == IDLE && start_i) begin
            reuse_reg <= weight_reuse_i;
        end
    end

    assign reuse_active = reuse_reg;
`else
    logic unused_weight_reuse;

    assign unused_weight_reuse = weight_reuse_i;
    assign reuse_active        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. In the load states, s_valid_i alone implies a
    // handshake because ready is high there.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = (tile_count_i == '0) ? DONE : LOAD_W;
                end
            end
            LOAD_W: begin
                if (s_valid_i) begin
                    state_next = LOAD_I;
                end
            end
            LOAD_I: begin
                if (s_valid_i && last_word) begin
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tile_ack_i) begin
                    if (last_tile) begin
                        state_next = DONE;
                    end else begin
                        state_next = reuse_active ? LOAD_I : LOAD_W;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Tile/word counters and latched run count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            tile_cnt_reg <= '0;
            word_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        count_reg    <= tile_count_i;
                        tile_cnt_reg <= '0;
                        word_cnt_reg <= '0;
                    end
                end
                LOAD_I: begin
                    if (s_valid_i) begin
                        word_cnt_reg <= last_word ? '0 : (word_cnt_reg + WORD_ONE);
                    end
                end
                WAIT_ACK: begin
                    if (tile_ack_i && !last_tile) begin
                        tile_cnt_reg <= tile_cnt_reg + TILE_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered load outputs. data_o and load_type_o hold between loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o      <= '0;
            load_en_o   <= 1'b0;
            load_type_o <= 1'b0;
        end else begin
            load_en_o <= handshake;
            if (handshake) begin
                data_o      <= s_data_i;
                load_type_o <= (state_reg == LOAD_I);
            end
        end
    end

endmodule
